// File: rtl/dmem_stage.sv
// Memory-access stage: byte/half/word stores into a synchronous data RAM and
// one-cycle-latency formatted loads, with misaligned accesses suppressed and flagged.
module dmem_stage #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwriteM,
  input  logic        memreadM,
  input  logic [1:0]  storesrcM,
  input  logic [2:0]  loadsrcM,
  input  logic [31:0] aluresultM,
  input  logic [31:0] writeDataM,
  output logic [31:0] readdataW,
  output logic        misalignW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            off;
  logic [3:0]            be;
  logic [31:0]           wlane;
  logic                  st_mis;
  logic                  ld_mis;
  logic                  st_en;
  logic                  mis_now;
  logic                  unused_addr_hi;

  logic [31:0] rdata_p1;
  logic [1:0]  off_p1;
  logic [2:0]  ls_p1;
  logic        ld_mis_p1;
  logic        vld_p1;
  logic        mis_p1;

  assign idx            = aluresultM[DEPTH_LOG2+1:2];
  assign off            = aluresultM[1:0];
  assign unused_addr_hi = ^aluresultM[31:DEPTH_LOG2+2];

  function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                           input logic [1:0]  o,
                                           input logic [2:0]  ls);
    logic [31:0]        shifted;
    logic signed [15:0] h;
    logic signed [7:0]  b;
    logic signed [31:0] hs;
    logic signed [31:0] bs;
    shifted = w >> {o, 3'b000};
    h       = o[1] ? w[31:16] : w[15:0];
    b       = shifted[7:0];
    hs      = h;
    bs      = b;
    case (ls)
      3'b000:  fmt_load = w;
      3'b001:  fmt_load = hs;
      3'b010:  fmt_load = bs;
      3'b011:  fmt_load = {16'h0000, h};
      3'b100:  fmt_load = {24'h000000, b};
      default: fmt_load = 32'h0000_0000;
    endcase
  endfunction

  // Stores replicate the sub-word across all lanes; byte enables pick the lane.
  always_comb begin
    be     = 4'b0000;
    wlane  = writeDataM;
    st_mis = 1'b0;
    case (storesrcM)
      2'b00: begin
        be     = 4'b1111;
        st_mis = (off != 2'b00);
      end
      2'b01: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlane  = {2{writeDataM[15:0]}};
        st_mis = off[0];
      end
      2'b10: begin
        be    = 4'b0001 << off;
        wlane = {4{writeDataM[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    ld_mis = 1'b0;
    case (loadsrcM)
      3'b000:         ld_mis = (off != 2'b00);
      3'b001, 3'b011: ld_mis = off[0];
      default:        ld_mis = 1'b0;
    endcase
  end

  assign st_en   = memwriteM && !rst && !st_mis && (be != 4'b0000);
  assign mis_now = (memwriteM && st_mis) || (memreadM && ld_mis);

  // MEM -> W boundary: RAM write, read-first RAM read and load attributes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (st_en && be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
    end
    if (memreadM) begin
      rdata_p1  <= mem[idx];
      off_p1    <= off;
      ls_p1     <= loadsrcM;
      ld_mis_p1 <= ld_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      mis_p1 <= 1'b0;
    end else begin
      vld_p1 <= memreadM;
      mis_p1 <= mis_now;
    end
  end

  // W: format the registered word.
  assign readdataW = (vld_p1 && !ld_mis_p1) ? fmt_load(rdata_p1, off_p1, ls_p1) : 32'h0000_0000;
  assign misalignW = mis_p1;

endmodule

// File: tb/tb_dmem_stage.sv
// Bench for dmem_stage: byte-addressed reference memory model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_dmem_stage;

  localparam int DL   = 10;
  localparam int MEMB = 4 << DL;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwriteM;
  logic        memreadM;
  logic [1:0]  storesrcM;
  logic [2:0]  loadsrcM;
  logic [31:0] aluresultM;
  logic [31:0] writeDataM;
  logic [31:0] readdataW;
  logic        misalignW;

  int ntotal = 0;
  int npass  = 0;

  dmem_stage #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .memwriteM(memwriteM), .memreadM(memreadM),
    .storesrcM(storesrcM), .loadsrcM(loadsrcM), .aluresultM(aluresultM),
    .writeDataM(writeDataM), .readdataW(readdataW), .misalignW(misalignW)
  );

  always #5 clk = ~clk;

  // Reference model: byte memory, results predicted for the following cycle.
  logic [7:0]  mb [int];
  logic [31:0] exp_rd;
  logic        exp_mis;
  logic        exp_known;
  logic        model_ready = 1'b0;

  always @(posedge clk) begin
    int a, nst, nld;
    bit sgn, mst, mld;
    logic [31:0] v;
    a   = int'(aluresultM % MEMB);
    nst = (storesrcM == 2'd0) ? 4 : (storesrcM == 2'd1) ? 2 : 1;
    case (loadsrcM)
      3'd0:         nld = 4;
      3'd1, 3'd3:   nld = 2;
      default:      nld = 1;
    endcase
    sgn = (loadsrcM == 3'd1) || (loadsrcM == 3'd2);
    mst = memwriteM && storesrcM != 2'd3 && (a % nst) != 0;
    mld = memreadM && loadsrcM <= 3'd4 && (a % nld) != 0;
    exp_known = 1'b1;
    if (rst) begin
      exp_rd  = 0;
      exp_mis = 0;
    end else begin
      exp_mis = mst || mld;
      exp_rd  = 0;
      if (memreadM && !mld && loadsrcM <= 3'd4) begin
        v = 0;
        for (int k = 0; k < nld; k++) begin
          if (mb.exists(a + k)) v = v | (32'(mb[a + k]) << (8 * k));
          else exp_known = 1'b0;
        end
        if (sgn && v[8*nld-1]) v = v | ~((32'd1 << (8 * nld)) - 32'd1);
        exp_rd = v;
      end
      if (memwriteM && storesrcM != 2'd3 && !mst)
        for (int k = 0; k < nst; k++) mb[a + k] = writeDataM[8*k +: 8];
    end
    model_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      ntotal++;
      if (misalignW === exp_mis) npass++;
      else $display("FAIL model_misalign t=%0t: got %b expected %b", $time, misalignW, exp_mis);
      if (exp_known) begin
        ntotal++;
        if (readdataW === exp_rd) npass++;
        else $display("FAIL model_readdata t=%0t: got %h expected %h", $time, readdataW, exp_rd);
      end
    end
  end

  task automatic drive(input logic r, input logic we, input logic re, input logic [1:0] ss,
                       input logic [2:0] ls, input logic [31:0] a, input logic [31:0] wd);
    rst = r; memwriteM = we; memreadM = re; storesrcM = ss;
    loadsrcM = ls; aluresultM = a; writeDataM = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [1:0] ss, input logic [31:0] a, input logic [31:0] wd);
    drive(1'b0, 1'b1, 1'b0, ss, 3'd0, a, wd);
  endtask

  task automatic ld(input logic [2:0] ls, input logic [31:0] a);
    drive(1'b0, 1'b0, 1'b1, 2'd0, ls, a, 32'h0);
  endtask

  task automatic lit(input string name, input logic [31:0] rd, input logic mis);
    ntotal++;
    if (readdataW === rd && misalignW === mis) npass++;
    else $display("FAIL %s: got rd=%h mis=%b expected rd=%h mis=%b", name, readdataW, misalignW, rd, mis);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    lit("reset_state", 32'h0, 1'b0);

    st(2'd0, 32'h100, 32'hDEADBEEF);
    ld(3'd0, 32'h100);                 lit("word_roundtrip", 32'hDEADBEEF, 1'b0);

    st(2'd0, 32'h40, 32'h0);
    st(2'd2, 32'h43, 32'hABCDEF80);
    st(2'd1, 32'h40, 32'h55551234);
    ld(3'd0, 32'h40);                  lit("lw_subword", 32'h80001234, 1'b0);
    ld(3'd2, 32'h43);                  lit("lb_sign", 32'hFFFFFF80, 1'b0);
    ld(3'd4, 32'h43);                  lit("lbu_zero", 32'h00000080, 1'b0);
    ld(3'd1, 32'h42);                  lit("lh_sign", 32'hFFFF8000, 1'b0);
    ld(3'd3, 32'h40);                  lit("lhu_zero", 32'h00001234, 1'b0);

    st(2'd0, 32'h200, 32'h01020304);
    st(2'd0, 32'h202, 32'hAAAAAAAA);   lit("sw_misalign", 32'h0, 1'b1);
    ld(3'd0, 32'h200);                 lit("sw_misalign_nowrite", 32'h01020304, 1'b0);
    ld(3'd1, 32'h201);                 lit("lh_misalign", 32'h0, 1'b1);
    ld(3'd2, 32'h201);                 lit("lb_odd_ok", 32'h00000003, 1'b0);
    st(2'd1, 32'h203, 32'hFFFF);       lit("sh_misalign", 32'h0, 1'b1);
    ld(3'd0, 32'h200);                 lit("sh_misalign_nowrite", 32'h01020304, 1'b0);

    st(2'd0, 32'h10, 32'h11111111);
    drive(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 32'h10, 32'h22222222);
    lit("read_during_write_old", 32'h11111111, 1'b0);
    ld(3'd0, 32'h10);                  lit("read_after_write_new", 32'h22222222, 1'b0);

    st(2'd0, 32'h20, 32'h33333333);
    ld(3'd0, 32'h20);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 32'h20, 32'h55555555);
    lit("reset_mid_op", 32'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 32'h22, 32'h55555555);
    lit("reset_misaligned", 32'h0, 1'b0);
    ld(3'd0, 32'h20);                  lit("reset_no_write", 32'h33333333, 1'b0);

    st(2'd0, 32'h1000, 32'hCAFEF00D);
    ld(3'd0, 32'h0);                   lit("wrap_around", 32'hCAFEF00D, 1'b0);
    st(2'd3, 32'h0, 32'h12345678);     lit("reserved_store", 32'h0, 1'b0);
    ld(3'd0, 32'h0);                   lit("reserved_store_nowrite", 32'hCAFEF00D, 1'b0);
    ld(3'd5, 32'h0);                   lit("reserved_load", 32'h0, 1'b0);
    st(2'd1, 32'h2, 32'h0000BEEF);
    ld(3'd3, 32'h2);                   lit("lhu_upper", 32'h0000BEEF, 1'b0);
    ld(3'd2, 32'h0);                   lit("lb_low", 32'h0000000D, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    lit("idle", 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/dmem_stage.md
# dmem_stage

Memory-access stage of the five-stage RISC-V pipeline. It consumes the EX/MEM register outputs (ALU address, store data, load/store size controls), performs byte/half/word stores into an internal synchronous data RAM, and returns sign- or zero-extended load data one cycle later, aligned with the MEM/WB boundary. Misaligned accesses are suppressed and flagged.

## Interface

- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB)
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- memwriteM  input  1  store enable for the instruction in MEM
- memreadM  input  1  load enable for the instruction in MEM
- storesrcM  input  2  store size: 00 SW, 01 SH, 10 SB, 11 reserved (treated as no store)
- loadsrcM  input  3  load type: 000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU, others reserved (result 0)
- aluresultM  input  32  byte address
- writeDataM  input  32  store data (rs2), right-justified
- readdataW  output  32  formatted load data, valid in the cycle after the load is in MEM
- misalignW  output  1  high for one cycle when the access in the previous MEM cycle was misaligned

## Operation

- Word index = aluresultM[DEPTH_LOG2+1:2]; upper address bits ignored (addresses wrap modulo 4·2^DEPTH_LOG2 bytes). Byte offset off = aluresultM[1:0].
- Alignment: SW/LW require off==00; SH/LH/LHU require off[0]==0; SB/LB/LBU always aligned.
- Store (memwriteM=1, rst=0, aligned, storesrcM≠11): byte enables SW 1111; SH 0011 (off=00) or 1100 (off=10); SB one-hot at bit off. Data lane placement: SH writes writeDataM[15:0] into the selected half; SB writes writeDataM[7:0] into the selected byte. Unselected bytes unchanged.
- Misaligned store: no RAM write, misalignW=1 next cycle.
- Load (memreadM=1): RAM word read synchronously; off, loadsrcM, and the alignment result captured in a register alongside the read.
- Load formatting (combinational on registered data): LW whole word; LH/LHU half selected by off[1], sign/zero-extended; LB/LBU byte selected by off, sign/zero-extended; reserved encoding -> 0.
- Misaligned load: readdataW=0, misalignW=1.
- memreadM and memwriteM both high: store takes effect (if aligned); load returns the old word (read-first), formatted per loadsrcM.
- No access (both low): readdataW=0, misalignW=0 next cycle.
- RAM contents are not cleared by reset (undefined until written; bench preloads or writes first).

## Timing

- Store: RAM updated at the rising edge where memwriteM=1; visible to a load in MEM on the following cycle.
- Load latency: 1 cycle; address in MEM at edge N, readdataW valid after edge N+1 until edge N+2 (stall-free pipeline, no hold/enable port).
- Read-during-write to same word in the same cycle: old data returned.
- Back-to-back store then load to same address (consecutive cycles): load returns new data.
- Reset: while rst=1 at an edge, RAM writes suppressed, readdataW=0 and misalignW=0 after that edge. Load issued in the cycle rst asserts is discarded; first valid result is one cycle after the first post-reset load.
- misalignW is a one-cycle pulse per offending instruction, never sticky.

## Test plan

- Word round trip: SW 0xDEADBEEF to 0x100, next cycle LW 0x100 -> readdataW=0xDEADBEEF one cycle later, misalignW=0.
- Sub-word store/load: SW 0x00000000 @0x40, SB 0x80 @0x43, SH 0x1234 @0x40 -> LW @0x40 = 0x80001234; LB @0x43 = 0xFFFFFF80; LBU @0x43 = 0x00000080; LH @0x42 = 0xFFFF8000; LHU @0x40 = 0x00001234.
- Misalignment: SW 0xAAAAAAAA @0x202 -> misalignW=1 one cycle, LW @0x200 returns prior contents; LH @0x201 -> readdataW=0, misalignW=1; LB @0x201 -> misalignW=0.
- Read-during-write: word @0x10 = 0x11111111; same cycle memread+memwrite SW 0x22222222 @0x10 -> readdataW=0x11111111; next LW -> 0x22222222.
- Reset mid-operation: assert rst during SW 0x55555555 @0x20 and a concurrent load -> word @0x20 unchanged, readdataW=0 and misalignW=0 after edge.
- Wrap-around: DEPTH_LOG2=10, SW 0xCAFEF00D @0x1000 -> LW @0x0 returns 0xCAFEF00D.
